fd_circle_fetch: RTL

//  Frame scanner and pixel gatherer for the FAST-9 datapath. Steps a reference pixel across the

---
 rtl/fd_circle_fetch.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fd_circle_fetch.sv
// FAST-9 frame scanner: fetches each scan pixel's center and radius-3 ring from SRAM and presents them as one bundle.
// Optional FD_HIGH_SPEED_TEST_EN: cardinal-pixel early reject via a CHECK state before the full ring fetch.
module fd_circle_fetch #(
    parameter int COLUMNS = 180,
    parameter int ROWS    = 120
`ifdef FD_HIGH_SPEED_TEST_EN
    ,
    parameter int THRESH  = 20
`endif
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         sram_rd,
    output logic [14:0]  sram_addr,
    input  logic [7:0]   sram_rdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [14:0]  out_addr,
    output logic [7:0]   out_center,
    output logic [127:0] out_circle
);
    localparam int C = COLUMNS;
    localparam logic [14:0] FIRST_ADDR = 15'(3 * C + 3);
    localparam logic [14:0] LAST_ADDR  = 15'((ROWS - 4) * C + C - 4);
    localparam logic [14:0] COL_FIRST  = 15'(3);
    localparam logic [14:0] COL_LAST   = 15'(C - 4);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_CHECK, S_DONE} state_t;

    state_t       r_state, w_next;
    logic [4:0]   r_idx;
    logic [14:0]  r_ref, r_col;
    logic         r_cap_vld;
    logic [4:0]   r_cap_slot;
    logic [7:0]   r_pix [17];
    logic [4:0]   w_slot;
    logic [3:0]   w_k;
    logic [14:0]  w_off;
    logic         w_last, w_new_pixel;

    function automatic logic [14:0] ring_off(input logic [3:0] k);
        case (k)
            4'd0:    return 15'(-3 * C);
            4'd1:    return 15'(-3 * C + 1);
            4'd2:    return 15'(-2 * C + 2);
            4'd3:    return 15'(-C + 3);
            4'd4:    return 15'(3);
            4'd5:    return 15'(C + 3);
            4'd6:    return 15'(2 * C + 2);
            4'd7:    return 15'(3 * C + 1);
            4'd8:    return 15'(3 * C);
            4'd9:    return 15'(3 * C - 1);
            4'd10:   return 15'(2 * C - 2);
            4'd11:   return 15'(C - 3);
            4'd12:   return 15'(-3);
            4'd13:   return 15'(-C - 3);
            4'd14:   return 15'(-2 * C - 2);
            default: return 15'(-3 * C - 1);
        endcase
    endfunction

    // Slot 0 is the center, slot k+1 is ring pixel k.
    function automatic logic [4:0] fetch_slot(input logic [4:0] idx);
`ifdef FD_HIGH_SPEED_TEST_EN
        case (idx)
            5'd0:    return 5'd0;
            5'd1:    return 5'd1;
            5'd2:    return 5'd5;
            5'd3:    return 5'd9;
            5'd4:    return 5'd13;
            5'd5:    return 5'd2;
            5'd6:    return 5'd3;
            5'd7:    return 5'd4;
            5'd8:    return 5'd6;
            5'd9:    return 5'd7;
            5'd10:   return 5'd8;
            5'd11:   return 5'd10;
            5'd12:   return 5'd11;
            5'd13:   return 5'd12;
            5'd14:   return 5'd14;
            5'd15:   return 5'd15;
            default: return 5'd16;
        endcase
`else
        return idx;
`endif
    endfunction

    assign w_slot = fetch_slot(r_idx);
    assign w_k    = 4'(w_slot - 5'd1);
    assign w_off  = (w_slot == 5'd0) ? 15'd0 : ring_off(w_k);
    assign w_last = (r_ref == LAST_ADDR);

`ifdef FD_HIGH_SPEED_TEST_EN
    logic       w_keep;
    logic [2:0] w_bright, w_dark;
    logic [7:0] w_card [4];

    // Ring pixel 12 is still on the read bus during CHECK, so it bypasses the slot array.
    always_comb begin
        w_card[0] = r_pix[1];
        w_card[1] = r_pix[5];
        w_card[2] = r_pix[9];
        w_card[3] = sram_rdata;
        w_bright  = '0;
        w_dark    = '0;
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, w_card[i]} > ({1'b0, r_pix[0]} + 9'(THRESH))) w_bright = w_bright + 3'd1;
            if (({1'b0, w_card[i]} + 9'(THRESH)) < {1'b0, r_pix[0]}) w_dark = w_dark + 3'd1;
        end
        w_keep = (w_bright >= 3'd2) || (w_dark >= 3'd2);
    end

    assign w_new_pixel = (((r_state == S_PRESENT) && out_ready) ||
                          ((r_state == S_CHECK) && !w_keep)) && !w_last;
`else
    assign w_new_pixel = (r_state == S_PRESENT) && out_ready && !w_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FETCH;
`ifdef FD_HIGH_SPEED_TEST_EN
            S_FETCH:   if (r_idx == 5'd4) w_next = S_CHECK;
                       else if (r_idx == 5'd16) w_next = S_DRAIN;
            S_CHECK:   if (!w_keep && w_last) w_next = S_DONE;
                       else w_next = S_FETCH;
`else
            S_FETCH:   if (r_idx == 5'd16) w_next = S_DRAIN;
`endif
            S_DRAIN:   w_next = S_PRESENT;
            S_PRESENT: if (out_ready) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        sram_rd    = (r_state == S_FETCH);
        sram_addr  = (r_state == S_FETCH) ? (r_ref + w_off) : 15'd0;
        out_valid  = (r_state == S_PRESENT);
        out_addr   = '0;
        out_center = '0;
        out_circle = '0;
        if (r_state == S_PRESENT) begin
            out_addr   = r_ref;
            out_center = r_pix[0];
            for (int k = 0; k < 16; k++) out_circle[8*k +: 8] = r_pix[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            r_cap_vld <= (r_state == S_FETCH);
            if (r_state == S_FETCH)                        r_idx <= r_idx + 5'd1;
            else if (w_new_pixel || (r_state == S_IDLE))   r_idx <= '0;
        end
    end

    // Read data lands one cycle after its strobe, so the slot travels alongside.
    always_ff @(posedge clk) begin
        r_cap_slot <= w_slot;
        if (r_cap_vld) r_pix[r_cap_slot] <= sram_rdata;
        if ((r_state == S_IDLE) && start) begin
            r_ref <= FIRST_ADDR;
            r_col <= COL_FIRST;
        end else if (w_new_pixel) begin
            if (r_col == COL_LAST) begin
                r_ref <= r_ref + 15'd7;
                r_col <= COL_FIRST;
            end else begin
                r_ref <= r_ref + 15'd1;
                r_col <= r_col + 15'd1;
            end
        end
    end
endmodule
